// File: rtl/sha256_msg_schedule_pkg.sv
// Shared types and small-sigma helpers for the SHA-256 message schedule.
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_e;

  localparam int MSG_WORDS = 16;
  localparam int ROUNDS    = 64;

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sigma0_small(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1: ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sigma1_small(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Message-in / schedule-out stream bundle between the block and its neighbours.
interface sha256_msg_schedule_if #(parameter int WIDTH = 32);
  logic             i_start;
  logic             i_m_valid;
  logic [WIDTH-1:0] i_m_data;
  logic             o_m_ready;
  logic             o_w_valid;
  logic [WIDTH-1:0] o_w_data;
  logic [5:0]       o_w_idx;
  logic             i_w_ready;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_m_valid, i_m_data, i_w_ready,
    input  o_m_ready, o_w_valid, o_w_data, o_w_idx, o_busy, o_done
  );

  modport slave (
    input  i_start, i_m_valid, i_m_data, i_w_ready,
    output o_m_ready, o_w_valid, o_w_data, o_w_idx, o_busy, o_done
  );
endinterface

// File: rtl/sha256_sigma_small.sv
// Combinational SHA-256 small sigma; SEL=0 gives sigma0, SEL=1 gives sigma1.
module sha256_sigma_small
  import sha256_pkg::*;
#(
  parameter int SEL = 0
) (
  input  logic [31:0] x,
  output logic [31:0] y
);

  generate
    if (SEL == 0) begin : g_s0
      assign y = sigma0_small(x);
    end else begin : g_s1
      assign y = sigma1_small(x);
    end
  endgenerate

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads M[0..15], expands W[16..63] over a 16-word
// sliding window and streams W[0..63] through a single output register.
module sha256_msg_schedule #(
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sha256_msg_schedule_if.slave  bus
);
  import sha256_pkg::*;

  localparam logic [5:0] LAST_MSG = 6'(MSG_WORDS - 1);
  localparam logic [5:0] LAST_W   = 6'(ROUNDS - 1);

  state_e                          state, state_nxt;
  logic [5:0]                      t;
  logic [MSG_WORDS-1:0][WIDTH-1:0] win;
  logic                            w_valid, done_q;
  logic [WIDTH-1:0]                w_data;
  logic [5:0]                      w_idx;

  logic             adv, w_hs, m_ready, m_acc, w_load;
  logic [WIDTH-1:0] s0, s1, w_exp, w_nxt;

  assign adv   = !w_valid || bus.i_w_ready;
  assign w_hs  = w_valid && bus.i_w_ready;
  assign m_acc = bus.i_m_valid && m_ready;

  // win[14] = W[t-2], win[1] = W[t-15]
  sha256_sigma_small #(.SEL(0)) u_s0 (.x(win[1]),  .y(s0));
  sha256_sigma_small #(.SEL(1)) u_s1 (.x(win[14]), .y(s1));

  assign w_exp = s1 + win[9] + s0 + win[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start)              state_nxt = LOAD;
      LOAD:    if (m_acc && t == LAST_MSG)   state_nxt = EXPAND;
      EXPAND:  if (adv && t == LAST_W)       state_nxt = DRAIN;
      DRAIN:   if (w_hs)                     state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_ready = 1'b0;
    w_load  = 1'b0;
    w_nxt   = w_exp;
    case (state)
      LOAD: begin
        m_ready = adv;
        w_load  = bus.i_m_valid && adv;
        w_nxt   = bus.i_m_data;
      end
      EXPAND: w_load = adv;
      default: ;
    endcase
  end

  // Counter, window and output register all advance only on a load, so a
  // stalled output freezes the whole schedule.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      t       <= '0;
      win     <= '0;
      w_valid <= 1'b0;
      w_data  <= '0;
      w_idx   <= '0;
      done_q  <= 1'b0;
    end else begin
      if (state == IDLE && bus.i_start) t <= '0;
      else if (w_load)                  t <= t + 6'd1;

      if (w_load) begin
        win     <= {w_nxt, win[MSG_WORDS-1:1]};
        w_valid <= 1'b1;
        w_data  <= w_nxt;
        w_idx   <= t;
      end else if (w_hs) begin
        w_valid <= 1'b0;
      end

      done_q <= (state == DRAIN) && w_hs;
    end
  end

  assign bus.o_m_ready = m_ready;
  assign bus.o_w_valid = w_valid;
  assign bus.o_w_data  = w_data;
  assign bus.o_w_idx   = w_idx;
  assign bus.o_busy    = (state != IDLE);
  assign bus.o_done    = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: reference schedule pushed at
// stimulus time, popped and compared on every W handshake.
module tb_sha256_msg_schedule;

  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  sha256_msg_schedule_if #(.WIDTH(32)) ifc();

  sha256_msg_schedule #(.WIDTH(32), .ROUNDS(64)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (ifc)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] blk[16];
  logic [31:0] got[64];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          bp_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [5:0]  prev_idx;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic push_expected();
    logic [31:0] w[64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[i];
      else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      sb.push_back({6'(i), w[i]});
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    #1;
    ifc.i_w_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge i_clk) begin
    if (!i_rst_n) stall_prev = 1'b0;
    else begin
      if (ifc.o_done) begin done_cnt++; done_cyc = cyc; end
      if (stall_prev) begin
        chk("stall_valid", ifc.o_w_valid, 1);
        chk("stall_data", ifc.o_w_data, prev_data);
        chk("stall_idx", ifc.o_w_idx, prev_idx);
      end
      if (ifc.o_w_valid && ifc.i_w_ready) begin
        if (sb.size() == 0) chk("w_extra_idx", ifc.o_w_idx, 64'd64);
        else begin
          e = sb.pop_front();
          chk("w_idx", ifc.o_w_idx, e.idx);
          chk("w_data", ifc.o_w_data, e.data);
          got[ifc.o_w_idx] = ifc.o_w_data;
        end
      end
      stall_prev = ifc.o_w_valid && !ifc.i_w_ready;
      prev_data  = ifc.o_w_data;
      prev_idx   = ifc.o_w_idx;
    end
  end

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_w_valid"}, ifc.o_w_valid, 0);
    chk({pfx, "_w_data"},  ifc.o_w_data, 0);
    chk({pfx, "_w_idx"},   ifc.o_w_idx, 0);
    chk({pfx, "_m_ready"}, ifc.o_m_ready, 0);
    chk({pfx, "_busy"},    ifc.o_busy, 0);
    chk({pfx, "_done"},    ifc.o_done, 0);
  endtask

  task automatic feed(input bit gaps);
    int  k = 0;
    int  g = 0;
    bit  hs;
    while (k < 16 && g < 2000) begin
      ifc.i_m_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ifc.i_m_data  = blk[k];
      @(negedge i_clk);
      hs = ifc.i_m_valid && ifc.o_m_ready;
      @(posedge i_clk); #1;
      if (hs) k++;
      g++;
    end
    ifc.i_m_valid = 1'b0;
    ifc.i_m_data  = $urandom;
    chk("feed_words", k, 16);
  endtask

  task automatic run_block(input bit gaps, input bit lat_chk, input bit pulse30);
    int d0, g, sc;
    d0 = done_cnt;
    push_expected();
    ifc.i_start = 1'b1;
    sc = cyc;
    @(posedge i_clk); #1;
    ifc.i_start = 1'b0;
    fork
      feed(gaps);
      if (pulse30) begin
        int gp = 0;
        while (!(ifc.o_w_valid && ifc.o_w_idx == 6'd30) && gp < 1000) begin
          @(negedge i_clk); gp++;
        end
        chk("reach_idx30", ifc.o_w_idx, 30);
        @(posedge i_clk); #1 ifc.i_start = 1'b1;
        @(posedge i_clk); #1 ifc.i_start = 1'b0;
      end
    join
    g = 0;
    while (done_cnt == d0 && g < 3000) begin @(posedge i_clk); #1; g++; end
    if (lat_chk) chk("done_cycle", done_cyc - sc, 66);
    repeat (5) @(posedge i_clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("sb_drained", sb.size(), 0);
    chk("idle_busy", ifc.o_busy, 0);
  endtask

  task automatic load_abc();
    foreach (blk[i]) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  initial begin
    int g;
    // reset with random inputs
    i_rst_n       = 1'b0;
    ifc.i_start   = 1'($urandom_range(0, 1));
    ifc.i_m_valid = 1'($urandom_range(0, 1));
    ifc.i_m_data  = $urandom;
    ifc.i_w_ready = 1'($urandom_range(0, 1));
    #12;
    chk_outputs_zero("rst");
    ifc.i_start = 1'b0;
    ifc.i_m_valid = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk_outputs_zero("post_rst");

    // abc at full rate
    load_abc();
    run_block(1'b0, 1'b1, 1'b0);
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000F0000);

    // all-zero block
    foreach (blk[i]) blk[i] = 32'h0;
    run_block(1'b0, 1'b1, 1'b0);

    // random backpressure and gapped input
    load_abc();
    bp_en = 1'b1;
    run_block(1'b1, 1'b0, 1'b0);
    bp_en = 1'b0;
    @(posedge i_clk); #1;

    // random message, start pulse while expanding
    foreach (blk[i]) blk[i] = $urandom;
    run_block(1'b0, 1'b1, 1'b1);

    // reset mid-EXPAND at idx 40
    load_abc();
    push_expected();
    ifc.i_start = 1'b1;
    @(posedge i_clk); #1 ifc.i_start = 1'b0;
    feed(1'b0);
    g = 0;
    while (!(ifc.o_w_valid && ifc.o_w_idx == 6'd40) && g < 500) begin
      @(negedge i_clk); g++;
    end
    chk("reach_idx40", ifc.o_w_idx, 40);
    #2 i_rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_rst");
    sb.delete();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    foreach (got[i]) got[i] = 32'hDEADBEEF;
    run_block(1'b0, 1'b1, 1'b0);
    chk("rerun_w0", got[0], 32'h61626380);
    chk("rerun_w17", got[17], 32'h000F0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Upstream operand source for the SHA-256 round datapath. It accepts the 16 message words of one 512-bit block over a valid/ready stream and emits the full schedule W[0..63], one word per handshake. Each emitted word is the W operand fed into the 7:2 carry-save reduction of a round, alongside h, Σ1, Ch, K, Σ0 and Maj. It expands words 16..63 internally using a 16-word sliding window.

## Interface
Parameters:
- WIDTH, 32: word width. Only 32 is supported; the σ rotation amounts are fixed for SHA-256.
- ROUNDS, 64: number of schedule words emitted per block.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  begin a new block. Sampled only in IDLE.
- i_m_valid  in  1  a message word is present on i_m_data.
- i_m_data  in  WIDTH  message word M[t], big-endian word order, t = 0..15.
- o_m_ready  out  1  the block accepts a message word this cycle.
- o_w_valid  out  1  o_w_data and o_w_idx hold a schedule word.
- o_w_data  out  WIDTH  schedule word W[o_w_idx].
- o_w_idx  out  6  schedule index, 0..63.
- i_w_ready  in  1  the round logic consumes the word this cycle.
- o_busy  out  1  the state is not IDLE.
- o_done  out  1  one-cycle pulse in the cycle after the W[63] handshake.

## Operation
- Window: win[0..15], where win[15] is W[t-1] and win[0] is W[t-16]. A push shifts the window down and writes the new word into win[15].
- Output register: a single stage holding o_w_valid, o_w_data and o_w_idx.
- "adv" is true when the output register is empty or is being consumed: !o_w_valid || i_w_ready.
- Word counter t is 6 bits. It holds the index of the next word to produce.
- State IDLE:
  - o_m_ready = 0.
  - If i_start = 1, set t = 0 and go to LOAD.
- State LOAD:
  - o_m_ready = adv.
  - On an accepted word (i_m_valid && o_m_ready), the word goes into the output register with idx t, is pushed into the window, and t increments.
  - After the word with t = 15 is accepted, go to EXPAND.
- State EXPAND:
  - The next word is W = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], taken mod 2^32 with the carry discarded.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - When adv = 1, W is loaded into the output register with idx t, pushed into the window, and t increments.
  - After t = 63 is loaded, go to DRAIN.
- State DRAIN:
  - Nothing new is produced.
  - On the W[63] handshake, clear o_w_valid, go to IDLE and assert o_done for the next cycle.
- On a handshake with nothing new loaded in that cycle, o_w_valid clears.
- i_start outside IDLE is ignored.
- i_m_valid outside LOAD is ignored. No word is consumed.
- Reset, including mid-block: state = IDLE, t = 0, window all zero, o_w_valid = 0, o_w_data = 0, o_w_idx = 0, o_m_ready = 0, o_busy = 0, o_done = 0. A partially emitted block is abandoned.

## Timing
- i_start sampled high in cycle 0 gives o_m_ready = 1 in cycle 1.
- Latency from a message word handshake to its o_w_valid is one cycle. The same applies to a computed word loaded in EXPAND.
- Sustained throughput is 1 word per cycle when i_m_valid = 1 and i_w_ready = 1.
- Full block at full rate:
  - M[0..15] accepted in cycles 1..16.
  - W[16..63] loaded in cycles 17..64.
  - W[63] is valid in cycle 65.
  - o_done = 1 in cycle 66.
- Backpressure: while o_w_valid && !i_w_ready, the following hold stable:
  - o_w_data, o_w_idx, the window and t;
  - o_m_ready = 0.
- The σ and 4-operand add path is combinational in one cycle, from window registers to the output register.

## Structure
- sha256_pkg holds:
  - the state enum: IDLE, LOAD, EXPAND, DRAIN;
  - localparams MSG_WORDS = 16 and ROUNDS = 64;
  - functions sigma0_small and sigma1_small.
- Sub-module sha256_sigma_small:
  - parameter SEL = 0 or 1, selecting σ0 or σ1;
  - purely combinational;
  - instantiated twice.
- The top level holds the FSM, the counter, the window shift register and the output register.

## Test plan
- Reset values: assert i_rst_n = 0 with random inputs. All outputs must read 0 and state must be IDLE. Release reset with i_start = 0; the block stays idle with o_busy = 0.
- Block "abc" at full rate:
  - Stimulus: M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018.
  - Required: W16 = 0x61626380 and W17 = 0x000F0000.
  - Required: all 64 words match the reference model, with idx 0..63 in order.
  - Required: o_done in cycle 66.
- All-zero block: all 64 W must be 0. o_done must fire exactly once.
- Random backpressure:
  - Stimulus: i_w_ready toggled randomly and i_m_valid gapped, using the "abc" block.
  - Required: o_w_data and o_w_idx stable while stalled, no word lost or duplicated, identical word sequence.
- Start during busy: pulse i_start in EXPAND at idx 30. The sequence must be unaffected and o_done must pulse once.
- Reset mid-EXPAND at idx 40:
  - Required: outputs 0 immediately, without waiting for a clock edge.
  - Required: a following i_start and "abc" block reproduces W0 = 0x61626380 and the correct sequence, with no stale window data.
